alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Command-side sequencer for the 8-bit combinational ALU: it is the producer of A/B/ALU_Sel and the consumer of ALU_Out/CarryOut/Z/V.
- Accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues each command to the ALU, holds operands stable for one settle cycle, then registers the result and flags.
- Returns each result in order over a second valid/ready handshake.

Parameters:
- DEPTH, 4, command FIFO entries; must be a power of 2, minimum 2.
- CW, 3, width of cmd_count; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  4  ALU_Sel opcode, same encoding as the ALU.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- alu_a  out  8  drives ALU A.
- alu_b  out  8  drives ALU B.
- alu_sel  out  4  drives ALU_Sel.
- alu_out  in  8  ALU_Out.
- alu_carry  in  1  CarryOut.
- alu_z  in  1  Z.
- alu_v  in  1  V.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  8  captured result.
- rsp_flags  out  4  {dz, V, Z, C}.
- busy  out  1  high when state != IDLE or FIFO non-empty.
- cmd_count  out  CW  current FIFO occupancy.

Behaviour:
- Synchronous active-low reset on clk, sampled only at the rising edge. Reset is decided: one clock, synchronous, active-low.
- Reset values:
  - all outputs 0;
  - FIFO empty, cmd_ready=1;
  - state IDLE;
  - operand registers 0.
- FIFO:
  - Push on cmd_valid&&cmd_ready; pop is internal.
  - Simultaneous push and pop leaves cmd_count unchanged.
  - Pointers wrap modulo DEPTH.
  - No push when full: cmd_ready=0, and cmd_valid is ignored.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if FIFO non-empty, pop the head into operand registers (alu_a/alu_b/alu_sel) and go to ISSUE. Otherwise stay.
  - ISSUE: lasts exactly one cycle, with the ALU inputs stable. At the ending edge:
    - rsp_data<=alu_out;
    - rsp_flags<={dz,alu_v,alu_z,alu_carry};
    - rsp_valid<=1;
    - go to RESP.
  - RESP: hold rsp_* stable while rsp_valid&&!rsp_ready. On handshake:
    - if FIFO non-empty, pop the next command directly and go to ISSUE (rsp_valid<=0);
    - else rsp_valid<=0 and go to IDLE.
- alu_a/alu_b/alu_sel change only on a pop; they hold the last issued values at all other times (no idle glitching).
- Latency: a command accepted at edge E0 into an empty, idle block gives rsp_valid=1 after edge E0+2.
- Sustained throughput: one result per 2 cycles with rsp_ready tied high.
- Divide-by-zero: if the issued op==4'b0011 and operand B==0:
  - rsp_data=8'hFF;
  - rsp_flags=4'b1000 (dz=1, V=Z=C=0);
  - ALU outputs are ignored for that command.
  - For all other commands dz=0.
- Flags are passed through unmodified for all other opcodes, including undefined ALU semantics.
- Ordering: results are strictly in command-acceptance order.
- Reset mid-operation: FIFO contents and any pending response are discarded. No rsp_valid is produced for them.
- rsp_ready asserted while rsp_valid=0 has no effect.

Optional Feature:
- Macro: ALU_SEQ_CHAIN_EN.
- Defined:
  - adds input port cmd_chain (1 bit) after cmd_b, stored in the FIFO entry.
  - On pop with chain=1, operand A is the last captured rsp_data (reset 0; the dz result 8'hFF counts) instead of stored cmd_a.
  - Operand B and op are used as stored.
- Not defined: port absent and cmd_a is always used. All other behaviour is identical.

Test Plan:
- Basic add: cmd op=0, A=8'h0A, B=8'h02 with rsp_ready=1 -> rsp_valid high 2 cycles after accept; rsp_data=8'h0C; rsp_flags=4'b0000; busy then returns to 0.
- Carry and zero: op=0, A=8'hF0, B=8'h10 -> rsp_data=8'h00, flags C=1, Z=1 (rsp_flags[1:0]=2'b11); then op=4'b1111, A=B=8'h55 -> rsp_data=8'h01.
- Divide-by-zero: op=4'b0011, A=8'h10, B=0 -> rsp_data=8'hFF, rsp_flags=4'b1000; then op=3, A=8'h10, B=8'h04 -> 8'h04, dz=0.
- Backpressure/full, DEPTH=4, rsp_ready=0, cmd_valid held with 6 distinct adds:
  - exactly 5 accepted (1 in RESP, 4 in FIFO);
  - cmd_ready=0 and cmd_count=4;
  - the 6th is held.
  - Then rsp_ready=1 -> all results in order, one every 2 cycles; the 6th is accepted when cmd_ready rises.
- Reset mid-operation: 3 commands queued, rsp_valid=1; assert rst_n=0 for one cycle -> next cycle rsp_valid=0, cmd_count=0, alu_* all 0, cmd_ready=1; no stale results afterwards.
- Chain (ALU_SEQ_CHAIN_EN): op=0, A=1, B=2 (rsp 8'h03); then chain=1, op=2, A=8'hAA, B=3 -> alu_a=8'h03, rsp_data=8'h09. Without the macro the bench skips this check.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl : command-side sequencer for an 8-bit combinational ALU.
//
// Commands (op, A, B) arrive over a valid/ready handshake into a small FIFO.
// Each command is popped into the operand registers that drive the ALU, held
// for one settle cycle (ISSUE), and the ALU result and flags are captured into
// the response registers. Responses leave in order over a second valid/ready
// handshake. A divide (op 4'b0011) with B == 0 is answered with 8'hFF and
// flags 4'b1000 regardless of what the ALU drives.
//
// Optional feature (macro ALU_SEQ_CHAIN_EN): adds cmd_chain; a chained command
// takes operand A from the last captured rsp_data instead of its own cmd_a.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (cmd_ready = !full)
//   cmd_op, cmd_a, cmd_b         opcode and operands
//   cmd_chain                    chain flag (only with ALU_SEQ_CHAIN_EN)
//   alu_a, alu_b, alu_sel        registered drive to the ALU
//   alu_out, alu_carry, alu_z,
//   alu_v                        ALU result and flags
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_flags          captured result, flags {dz, V, Z, C}
//   busy                         FSM active or FIFO non-empty
//   cmd_count                    FIFO occupancy
module alu_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [7:0]    cmd_a,
  input  logic [7:0]    cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic          cmd_chain,
`endif
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_sel,
  input  logic [7:0]    alu_out,
  input  logic          alu_carry,
  input  logic          alu_z,
  input  logic          alu_v,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic [3:0]    rsp_flags,
  output logic          busy,
  output logic [CW-1:0] cmd_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, empty, full;
  logic          capture, release_rsp;
  logic [7:0]    head_a;
  logic [11:0]   result;

  logic [3:0]    op_mem [DEPTH];
  logic [7:0]    a_mem  [DEPTH];
  logic [7:0]    b_mem  [DEPTH];
`ifdef ALU_SEQ_CHAIN_EN
  logic          chain_mem [DEPTH];
`endif

  function automatic logic is_div_zero(input logic [3:0] op, input logic [7:0] b);
    return (op == 4'b0011) && (b == 8'h00);
  endfunction

  // Packs {data, dz, V, Z, C}; a divide by zero overrides the ALU entirely.
  function automatic logic [11:0] resolve_result(input logic dz, input logic [7:0] out,
                                                 input logic v, input logic z, input logic c);
    if (dz) return {8'hFF, 4'b1000};
    return {out, 1'b0, v, z, c};
  endfunction

  assign empty     = (cmd_count == '0);
  assign full      = (cmd_count == CW'(DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE) || !empty;
  assign result    = resolve_result(is_div_zero(alu_sel, alu_b), alu_out, alu_v, alu_z, alu_carry);

`ifdef ALU_SEQ_CHAIN_EN
  // rsp_data always holds the previous command's result by the time the next
  // command is popped, so it is the chain source.
  assign head_a = chain_mem[rd_ptr] ? rsp_data : a_mem[rd_ptr];
`else
  assign head_a = a_mem[rd_ptr];
`endif

  // Command FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr] <= cmd_op;
      a_mem[wr_ptr]  <= cmd_a;
      b_mem[wr_ptr]  <= cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
      chain_mem[wr_ptr] <= cmd_chain;
`endif
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cmd_count <= cmd_count + CW'(1);
        2'b01:   cmd_count <= cmd_count - CW'(1);
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = empty ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE:  pop = !empty;
      ISSUE: capture = 1'b1;
      RESP: begin
        release_rsp = rsp_ready;
        pop         = rsp_ready && !empty;
      end
      default: ;
    endcase
  end

  // Stage p0: operand registers, loaded only on pop so the ALU never glitches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (pop) begin
      alu_a   <= head_a;
      alu_b   <= b_mem[rd_ptr];
      alu_sel <= op_mem[rd_ptr];
    end
  end

  // Stage p1: response capture after the one-cycle settle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= result[11:4];
      rsp_flags <= result[3:0];
    end else if (release_rsp) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  localparam int NRAND = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
`ifdef ALU_SEQ_CHAIN_EN
  logic       cmd_chain = 1'b0;
`endif
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry, alu_z, alu_v;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic       busy;
  logic [2:0] cmd_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;

  typedef struct packed {logic [7:0] d; logic [3:0] f;} exp_t;
  exp_t       exp_q[$];
  logic [7:0] model_last = 8'h00;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
    .cmd_chain(cmd_chain),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_z(alu_z), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .busy(busy), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit ALU: returns {V, Z, C, out}
  function automatic logic [10:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] o;
    logic c, v;
    c = 1'b0; v = 1'b0; o = 8'h00;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; o = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (o[7] != a[7]); end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; o = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (o[7] != a[7]); end
      4'd2: o = a * b;
      4'd3: if (b == 8'h00) begin o = 8'h00; c = 1'b1; end else o = a / b;
      4'd4: o = a << 1;
      4'd5: o = a >> 1;
      4'd6: o = {a[6:0], a[7]};
      4'd7: o = {a[0], a[7:1]};
      4'd8: o = a & b;
      4'd9: o = a | b;
      4'd10: o = a ^ b;
      4'd11: o = ~(a | b);
      4'd12: o = ~(a & b);
      4'd13: o = ~(a ^ b);
      4'd14: o = (a > b) ? 8'h01 : 8'h00;
      default: o = (a == b) ? 8'h01 : 8'h00;
    endcase
    return {v, (o == 8'h00), c, o};
  endfunction

  // Expected response {data, dz, V, Z, C} for one command
  function automatic exp_t ref_result(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [10:0] r;
    exp_t e;
    if (op == 4'd3 && b == 8'h00) begin
      e.d = 8'hFF; e.f = 4'b1000;
    end else begin
      r = alu_fn(op, a, b);
      e.d = r[7:0]; e.f = {1'b0, r[10], r[9], r[8]};
    end
    return e;
  endfunction

  always_comb {alu_v, alu_z, alu_carry, alu_out} = alu_fn(alu_sel, alu_a, alu_b);

  // Scoreboard: sampled on the falling edge, i.e. the values the next rising edge acts on
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] a_eff;
    if (!rst_n) begin
      exp_q.delete();
      model_last = 8'h00;
    end else begin
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got data=%h flags=%b, required no response", rsp_data, rsp_flags);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_data, rsp_flags} !== {e.d, e.f}) begin
            n_fail++;
            $display("FAIL sb_order: got data=%h flags=%b, required data=%h flags=%b", rsp_data, rsp_flags, e.d, e.f);
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        a_eff = cmd_a;
`ifdef ALU_SEQ_CHAIN_EN
        if (cmd_chain) a_eff = model_last;
`endif
        e = ref_result(cmd_op, a_eff, cmd_b);
        model_last = e.d;
        exp_q.push_back(e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic ch);
    int t;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
    cmd_chain = ch;
`else
    if (ch) $display("note: chain request ignored in this build");
`endif
    t = 0;
    while (!cmd_ready && t < 200) begin cyc(); t++; end
    if (t >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: cmd_ready=%b, required 1 within 200 cycles", cmd_ready);
    end
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    while (!rsp_valid && t < 50) begin cyc(); t++; end
    n_checks++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL rsp_timeout: rsp_valid=%b, required 1 within 50 cycles", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_flags, alu_a, alu_b, alu_sel} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rv=%b rd=%h rf=%b a=%h b=%h sel=%h, required all 0",
               rsp_valid, rsp_data, rsp_flags, alu_a, alu_b, alu_sel);
    end
    n_checks++;
    if ({busy, cmd_count, cmd_ready} !== 5'b0_000_1) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b count=%0d ready=%b, required 0 0 1", busy, cmd_count, cmd_ready);
    end
  endtask

  task automatic test_basic_add();
    logic [2:0] rv;
    rsp_ready = 1'b1;
    send(4'd0, 8'h0A, 8'h02, 1'b0);
    rv[0] = rsp_valid; cyc();
    rv[1] = rsp_valid; cyc();
    rv[2] = rsp_valid;
    n_checks++;
    if (rv !== 3'b100) begin
      n_fail++;
      $display("FAIL add_latency: rsp_valid after E0,E0+1,E0+2 = %b%b%b, required 0,0,1", rv[0], rv[1], rv[2]);
    end
    n_checks++;
    if (rsp_data !== 8'h0C || rsp_flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL add_result: got %h/%b, required 0c/0000", rsp_data, rsp_flags);
    end
    cyc();
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_idle: busy=%b rsp_valid=%b, required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_carry_zero();
    rsp_ready = 1'b1;
    send(4'd0, 8'hF0, 8'h10, 1'b0);
    wait_rsp();
    n_checks++;
    if (rsp_data !== 8'h00 || rsp_flags[1:0] !== 2'b11) begin
      n_fail++;
      $display("FAIL carry_zero: got %h flags=%b, required 00 flags[1:0]=11", rsp_data, rsp_flags);
    end
    cyc();
    send(4'd15, 8'h55, 8'h55, 1'b0);
    wait_rsp();
    n_checks++;
    if (rsp_data !== 8'h01) begin
      n_fail++;
      $display("FAIL equal_op: got %h, required 01", rsp_data);
    end
    cyc();
  endtask

  task automatic test_div_zero();
    rsp_ready = 1'b1;
    send(4'd3, 8'h10, 8'h00, 1'b0);
    wait_rsp();
    n_checks++;
    if (rsp_data !== 8'hFF || rsp_flags !== 4'b1000) begin
      n_fail++;
      $display("FAIL div_zero: got %h/%b, required ff/1000", rsp_data, rsp_flags);
    end
    cyc();
    send(4'd3, 8'h10, 8'h04, 1'b0);
    wait_rsp();
    n_checks++;
    if (rsp_data !== 8'h04 || rsp_flags[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL div_normal: got %h dz=%b, required 04 dz=0", rsp_data, rsp_flags[3]);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int k, got, last, mingap, maxgap, n;
    logic acc;
    logic [7:0] exp_d [6];
    for (int i = 0; i < 6; i++) exp_d[i] = 8'(i * 17 + 1);
    rsp_ready = 1'b0;
    k = 0;
    cmd_op = 4'd0; cmd_a = 8'(k * 17); cmd_b = 8'h01; cmd_valid = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
    cmd_chain = 1'b0;
`endif
    for (int c = 0; c < 20; c++) begin
      acc = cmd_ready;
      cyc();
      if (acc) begin k++; cmd_a = 8'(k * 17); end
    end
    n_checks++;
    if (k !== 5) begin
      n_fail++;
      $display("FAIL full_accepted: got %0d accepted, required 5", k);
    end
    n_checks++;
    if (cmd_ready !== 1'b0 || cmd_count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_state: ready=%b count=%0d, required 0 4", cmd_ready, cmd_count);
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d[0]) begin
      n_fail++;
      $display("FAIL full_head: rv=%b data=%h, required 1 %h", rsp_valid, rsp_data, exp_d[0]);
    end
    rsp_ready = 1'b1;
    got = 0; last = 0; mingap = 99; maxgap = 0; n = 0;
    while (got < 6 && n < 100) begin
      if (rsp_valid) begin
        n_checks++;
        if (rsp_data !== exp_d[got]) begin
          n_fail++;
          $display("FAIL drain_data[%0d]: got %h, required %h", got, rsp_data, exp_d[got]);
        end
        if (got > 0) begin
          if (n - last < mingap) mingap = n - last;
          if (n - last > maxgap) maxgap = n - last;
        end
        last = n; got++;
      end
      acc = cmd_valid && cmd_ready;
      cyc(); n++;
      if (acc) begin k++; cmd_valid = 1'b0; end
    end
    n_checks++;
    if (got !== 6 || k !== 6) begin
      n_fail++;
      $display("FAIL drain_count: got %0d results, %0d accepted, required 6 6", got, k);
    end
    n_checks++;
    if (mingap !== 2 || maxgap !== 2) begin
      n_fail++;
      $display("FAIL drain_rate: gap min=%0d max=%0d, required 2 2", mingap, maxgap);
    end
    cmd_valid = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_chain();
`ifdef ALU_SEQ_CHAIN_EN
    rsp_ready = 1'b1;
    send(4'd0, 8'h01, 8'h02, 1'b0);
    wait_rsp();
    n_checks++;
    if (rsp_data !== 8'h03) begin
      n_fail++;
      $display("FAIL chain_first: got %h, required 03", rsp_data);
    end
    cyc();
    send(4'd2, 8'hAA, 8'h03, 1'b1);
    wait_rsp();
    n_checks++;
    if (alu_a !== 8'h03 || rsp_data !== 8'h09) begin
      n_fail++;
      $display("FAIL chain_second: alu_a=%h data=%h, required 03 09", alu_a, rsp_data);
    end
    cyc();
    cmd_chain = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    int seen;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd1, 8'(8'h40 + i), 8'h01, 1'b0);
    repeat (2) cyc();
    n_checks++;
    if (rsp_valid !== 1'b1 || cmd_count !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_pre: rv=%b count=%0d, required 1 3", rsp_valid, cmd_count);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    n_checks++;
    if ({rsp_valid, cmd_count, alu_a, alu_b, alu_sel, cmd_ready} !== {1'b0, 3'd0, 20'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset: rv=%b count=%0d a=%h b=%h sel=%h ready=%b, required 0 0 00 00 0 1",
               rsp_valid, cmd_count, alu_a, alu_b, alu_sel, cmd_ready);
    end
    rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) seen++;
      cyc();
    end
    n_checks++;
    if (seen !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_stale: %0d stale responses, busy=%b, required 0 0", seen, busy);
    end
  endtask

  task automatic test_random();
    int issued, accepted, base, t;
    logic acc;
    base = n_rsp; issued = 0; accepted = 0; acc = 1'b0; cmd_valid = 1'b0;
    for (int c = 0; c < 3000 && accepted < NRAND; c++) begin
      if (acc) begin cmd_valid = 1'b0; accepted++; end
      if (!cmd_valid && issued < NRAND && ($urandom % 3) != 0) begin
        cmd_op = 4'($urandom);
        cmd_a  = 8'($urandom);
        cmd_b  = (($urandom % 6) == 0) ? 8'h00 : 8'($urandom);
`ifdef ALU_SEQ_CHAIN_EN
        cmd_chain = 1'($urandom);
`endif
        cmd_valid = 1'b1; issued++;
      end
      rsp_ready = ($urandom % 4) != 0;
      acc = cmd_valid && cmd_ready;
      cyc();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    t = 0;
    while ((busy || rsp_valid) && t < 100) begin cyc(); t++; end
    n_checks++;
    if (accepted !== NRAND || (n_rsp - base) !== NRAND) begin
      n_fail++;
      $display("FAIL random_count: accepted=%0d responses=%0d, required %0d %0d", accepted, n_rsp - base, NRAND, NRAND);
    end
    n_checks++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_zero();
    test_div_zero();
    test_back_to_back();
    test_chain();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1, "timeout");
  end

endmodule
